rv32i_instr_encoder: RTL and testbench
======================================

Name: rv32i_instr_encoder

Overview:
- Inverse of the RV32I decoder: takes field-level instruction requests and packs them into legal 32-bit RV32I instruction words.
- Range-checks immediates and funct3 values, tags each legal word with a sequential imem byte address, and buffers results in an output FIFO.
- Feeds the testbench/program-loader path that writes instruction memory for the core.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, >=2)
- BASE_ADDR, 32'h0000_0000, byte address assigned to the first word after reset/clear

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of FIFO and address counter
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- in_cls  in  4  instruction class (package enum)
- in_rd  in  5  destination register
- in_rs1  in  5  source 1
- in_rs2  in  5  source 2
- in_funct3  in  3  funct3
- in_alt  in  1  funct7[5] select (SUB/SRA/SRAI)
- in_imm  in  32  full signed immediate/offset value (U-class: full upper value)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pop
- out_instr  out  32  encoded instruction
- out_addr  out  32  imem byte address of out_instr
- err  out  1  one-cycle pulse: accepted request was illegal and dropped
- err_cnt  out  8  saturating count of dropped requests

Behaviour:
- Reset: in_ready=1, out_valid=0, out_instr=0, out_addr=0, err=0, err_cnt=0, FIFO empty, addr counter=BASE_ADDR.
- in_ready = (count < DEPTH). There is no same-cycle pop-through: a full FIFO holds in_ready low even when out_ready is high.
- Accept cycle N: encode combinationally, then write to FIFO at the edge. out_valid is high in cycle N+1 if the FIFO was empty (latency 1).
- Encoding per class:
  - R: opcode 0110011, funct7 = {1'b0, in_alt, 5'b0}.
  - I_ALU: opcode 0010011. Shifts (f3 001/101) place in_imm[4:0] with funct7 = {0, in_alt, 00000}.
  - LOAD 0000011, JALR 1100111: I format.
  - STORE 0100011: S format.
  - BRANCH 1100011: B format.
  - JAL 1101111: J format.
  - LUI 0110111, AUIPC 0010111: U format, in_imm[31:12].
  - Fields not used by a format are zero.
- Illegal (request is consumed, nothing is written, address is not advanced, err pulses in N+1, err_cnt++ saturating at 255):
  - I/S immediate outside [-2048, 2047].
  - Shift immediate outside [0, 31], or in_alt=1 with f3=001.
  - B immediate outside [-4096, 4094] or odd.
  - J immediate outside [-2^20, 2^20-2] or odd.
  - U with in_imm[11:0] != 0.
  - LOAD f3 in {011, 110, 111}.
  - STORE f3 > 010.
  - BRANCH f3 in {010, 011}.
  - JALR f3 != 000.
  - R with in_alt=1 and f3 not in {000, 101}.
  - Undefined in_cls.
- Address: each legal write takes the current counter value, then the counter increments by 4 and wraps modulo 2^32.
- Simultaneous push and pop: count unchanged, both take effect.
- clear: empties the FIFO, resets the counter to BASE_ADDR, and suppresses any push or error in that cycle. err_cnt is kept.
- Reset mid-stream: all state returns to reset values immediately (asynchronous assert); deassertion is synchronous to clk.

Decomposition:
- rv32i_enc_pkg holds:
  - instr_cls_e enum (R=0, I_ALU=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8).
  - Opcode localparams shared with the decoder.
  - Immediate range constants.
- One sub-module, enc_fifo: generic DEPTH x 64 synchronous FIFO (instr+addr) with push/pop/clear, count, and asynchronous active-low reset.
- Encoding and legality checks stay as combinational logic in the top module.

Test Plan:
- R-type: R x3,x1,x2 alt=0 f3=000 -> 0x002081B3 at addr 0x0. Next, alt=1 -> 0x402081B3 at 0x4.
- I and S: I_ALU x1,x0 imm=5 -> 0x00500093. STORE rs1=1 rs2=2 f3=010 imm=8 -> 0x0020A423.
- J and U: JAL rd=1 imm=8 -> 0x008000EF. LUI rd=5 imm=0x12345000 -> 0x123452B7. Out_addr increments by 4.
- Illegal requests: I_ALU imm=2048, then BRANCH imm=3 -> two err pulses, err_cnt=2, no FIFO writes, next legal word gets the unchanged address.
- Backpressure (DEPTH=4): out_ready=0, drive 5 requests -> in_ready low after the 4th. Then pop 1 with a push held -> order and addresses preserved.
- clear with 3 entries and a concurrent push -> FIFO empty, out_valid=0, next word at BASE_ADDR. Assert rst_n=0 mid-stream -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/rv32i_enc_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_enc_pkg : shared instruction classes, opcodes and immediate limits
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv32i_enc_pkg;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I_ALU  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } instr_cls_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM13_MIN = -4096;
  localparam int signed IMM13_MAX = 4094;
  localparam int signed IMM21_MIN = -(1 << 20);
  localparam int signed IMM21_MAX = (1 << 20) - 2;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input int signed lo,
                                    input int signed hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_instr_encoder_fifo.sv
// ---------------------------------------------------------------------------
// enc_fifo : DEPTH x WIDTH synchronous FIFO with clear and occupancy count
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH)) && !clear_i;
  assign do_pop  = pop_i && (count_q != '0) && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder : packs field-level requests into RV32I words + address
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv32i_instr_encoder
  import rv32i_enc_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cls,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic        in_alt,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  instr_cls_e         cls;
  logic signed [31:0] imm_s;
  logic [31:0]        enc_instr;
  logic               enc_legal;
  logic               is_shift;
  logic [11:0]        imm_i;

  assign cls      = instr_cls_e'(in_cls);
  assign imm_s    = $signed(in_imm);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign imm_i    = in_imm[11:0];

  always_comb begin
    enc_instr = '0;
    enc_legal = 1'b0;
    case (cls)
      CLS_R: begin
        enc_instr = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
        enc_legal = !in_alt || (in_funct3 == 3'b000) || (in_funct3 == 3'b101);
      end
      CLS_I_ALU: begin
        if (is_shift) begin
          enc_instr = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM};
          enc_legal = (in_imm[31:5] == '0) && !(in_alt && (in_funct3 == 3'b001));
        end else begin
          enc_instr = {imm_i, in_rs1, in_funct3, in_rd, OPC_OP_IMM};
          enc_legal = in_range(imm_s, IMM12_MIN, IMM12_MAX);
        end
      end
      CLS_LOAD: begin
        enc_instr = {imm_i, in_rs1, in_funct3, in_rd, OPC_LOAD};
        enc_legal = in_range(imm_s, IMM12_MIN, IMM12_MAX) &&
                    (in_funct3 != 3'b011) && (in_funct3 != 3'b110) && (in_funct3 != 3'b111);
      end
      CLS_JALR: begin
        enc_instr = {imm_i, in_rs1, in_funct3, in_rd, OPC_JALR};
        enc_legal = in_range(imm_s, IMM12_MIN, IMM12_MAX) && (in_funct3 == 3'b000);
      end
      CLS_STORE: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
        enc_legal = in_range(imm_s, IMM12_MIN, IMM12_MAX) && (in_funct3 <= 3'b010);
      end
      CLS_BRANCH: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OPC_BRANCH};
        enc_legal = in_range(imm_s, IMM13_MIN, IMM13_MAX) && !in_imm[0] &&
                    (in_funct3 != 3'b010) && (in_funct3 != 3'b011);
      end
      CLS_JAL: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
        enc_legal = in_range(imm_s, IMM21_MIN, IMM21_MAX) && !in_imm[0];
      end
      CLS_LUI: begin
        enc_instr = {in_imm[31:12], in_rd, OPC_LUI};
        enc_legal = (in_imm[11:0] == 12'h000);
      end
      CLS_AUIPC: begin
        enc_instr = {in_imm[31:12], in_rd, OPC_AUIPC};
        enc_legal = (in_imm[11:0] == 12'h000);
      end
      default: begin
        enc_instr = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  logic             accept, push, drop, pop;
  logic [31:0]      addr_q, addr_d;
  logic             err_q;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [63:0]      head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign in_ready = (fifo_count < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  // A clear cycle still consumes the request but neither stores nor flags it.
  assign push     = accept && enc_legal && !clear;
  assign drop     = accept && !enc_legal && !clear;
  assign pop      = out_valid && out_ready;

  always_comb begin
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    if (clear)     addr_d = BASE_ADDR;
    else if (push) addr_d = addr_q + 32'd4;
    if (drop && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      addr_q    <= addr_d;
      err_q     <= drop;
      err_cnt_q <= err_cnt_d;
    end
  end

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .push_i  (push),
    .wdata_i ({enc_instr, addr_q}),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = out_valid ? head[63:32] : 32'h0;
  assign out_addr  = out_valid ? head[31:0]  : 32'h0;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv32i_instr_encoder : randomized scoreboard bench for the RV32I encoder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rv32i_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cls = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb_q [$];
  int          occ = 0;
  logic [31:0] m_addr = BASE;
  logic        exp_err = 1'b0;
  int          exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input longint f7, input longint rs2, input longint rs1,
                                       input longint f3, input longint rd, input longint opc);
    return 32'((f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + opc);
  endfunction

  // Reference encoder: builds words from field arithmetic and checks ranges numerically.
  function automatic bit ref_enc(input int cls, input int rd, input int rs1, input int rs2,
                                 input int f3, input bit alt, input logic [31:0] imm,
                                 output logic [31:0] w);
    longint v   = longint'($signed(imm));
    longint u   = longint'(imm);
    longint f7a = alt ? 32 : 0;
    w = '0;
    case (cls)
      0: begin
        w = pack(f7a, rs2, rs1, f3, rd, 'h33);
        return !alt || f3 == 0 || f3 == 5;
      end
      1: begin
        if (f3 == 1 || f3 == 5) begin
          w = pack(f7a, u % 32, rs1, f3, rd, 'h13);
          return v >= 0 && v <= 31 && !(alt && f3 == 1);
        end
        w = pack((u >> 5) % 128, u % 32, rs1, f3, rd, 'h13);
        return v >= -2048 && v <= 2047;
      end
      2: begin
        w = pack((u >> 5) % 128, u % 32, rs1, f3, rd, 'h03);
        return v >= -2048 && v <= 2047 && f3 != 3 && f3 != 6 && f3 != 7;
      end
      3: begin
        w = pack((u >> 5) % 128, rs2, rs1, f3, u % 32, 'h23);
        return v >= -2048 && v <= 2047 && f3 <= 2;
      end
      4: begin
        w = pack(((u >> 12) % 2) * 64 + (u >> 5) % 64, rs2, rs1, f3,
                 ((u >> 1) % 16) * 2 + (u >> 11) % 2, 'h63);
        return v >= -4096 && v <= 4094 && (u % 2) == 0 && f3 != 2 && f3 != 3;
      end
      5: begin
        w = 32'(((((u >> 20) % 2) << 19) + (((u >> 1) % 1024) << 9) +
                 (((u >> 11) % 2) << 8) + ((u >> 12) % 256)) * 4096 + rd * 128 + 'h6F);
        return v >= -(64'sd1 << 20) && v <= (64'sd1 << 20) - 2 && (u % 2) == 0;
      end
      6: begin
        w = pack((u >> 5) % 128, u % 32, rs1, f3, rd, 'h67);
        return v >= -2048 && v <= 2047 && f3 == 0;
      end
      7, 8: begin
        w = 32'((u / 4096) * 4096 + rd * 128 + (cls == 7 ? 'h37 : 'h17));
        return (u % 4096) == 0;
      end
      default: return 1'b0;
    endcase
  endfunction

  // Model: consumes accepted requests at each edge and queues expected words.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      sb_q.delete(); occ = 0; m_addr = BASE; exp_err = 1'b0; exp_cnt = 0;
    end else begin
      logic [31:0] w;
      bit lg, acc;
      acc = in_valid && (occ < DEPTH);
      lg  = ref_enc(int'(in_cls), int'(in_rd), int'(in_rs1), int'(in_rs2),
                    int'(in_funct3), in_alt, in_imm, w);
      exp_err = 1'b0;
      if (clear) begin
        sb_q.delete(); occ = 0; m_addr = BASE;
      end else begin
        if (occ > 0 && out_ready) occ--;
        if (acc && lg) begin
          sb_q.push_back({w, m_addr}); m_addr += 32'd4; occ++;
        end else if (acc) begin
          exp_err = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end
    end
  end

  // Monitor: checks handshake/status every cycle and pops the scoreboard on each DUT pop.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(occ < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(occ != 0));
      chk("err", 32'(err), 32'(exp_err));
      chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      if (out_valid && out_ready && !clear) begin
        if (sb_q.size() == 0) begin
          chk("pop_unexpected", 32'(out_valid), 32'd0);
        end else begin
          logic [63:0] e;
          e = sb_q.pop_front();
          chk("out_instr", out_instr, e[63:32]);
          chk("out_addr", out_addr, e[31:0]);
        end
      end
    end
  end

  task automatic send(input int cls, input int rd, input int rs1, input int rs2,
                      input int f3, input bit alt, input logic [31:0] imm);
    bit ok = 1'b0;
    in_valid = 1'b1; in_cls = 4'(cls); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_alt = alt; in_imm = imm;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (occ < DEPTH) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (occ == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
    chk({tag, "_out_addr"}, out_addr, 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  function automatic logic [31:0] rand_imm();
    int bnd [14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                     1048574, 1048576, -1048576, -1048578, 31, 32};
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 31));
      1: return 32'(int'($urandom_range(0, 10000)) - 5000);
      2: return 32'(bnd[$urandom_range(0, 13)]);
      3: return $urandom;
      default: return {$urandom_range(0, 32'hFFFFF), 12'h000};
    endcase
  endfunction

  initial begin
    #3;
    check_reset_outputs("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(0, 3, 1, 2, 0, 0, 32'd0);
    send(0, 3, 1, 2, 0, 1, 32'd0);
    send(1, 1, 0, 0, 0, 0, 32'd5);
    send(3, 0, 1, 2, 2, 0, 32'd8);
    send(5, 1, 0, 0, 0, 0, 32'd8);
    send(7, 5, 0, 0, 0, 0, 32'h1234_5000);
    send(1, 1, 0, 0, 0, 0, 32'd2048);
    send(4, 0, 1, 2, 0, 0, 32'd3);
    send(1, 2, 3, 0, 5, 1, 32'd7);
    wait_drain();

    out_ready = 1'b0;
    fork
      for (int k = 0; k < 5; k++) send(0, k + 1, k, k + 2, 0, 0, 32'd0);
      begin
        for (int i = 0; i < 100 && occ < DEPTH; i++) @(negedge clk);
        @(posedge clk); @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    join
    out_ready = 1'b1;
    wait_drain();

    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(6, k, k, 0, 0, 0, 32'(k * 4));
    in_valid = 1'b1; in_cls = 4'd0; in_funct3 = 3'd0; in_alt = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    send(8, 7, 0, 0, 0, 0, 32'hABCD_E000);
    wait_drain();

    for (int n = 0; n < 300; n++) begin
      int c;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 30) == 0) begin
        in_valid = $urandom_range(0, 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
      end
      c = ($urandom_range(0, 20) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      send(c, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 7), $urandom_range(0, 1), rand_imm());
    end
    out_ready = 1'b1;
    wait_drain();

    for (int n = 0; n < 260; n++) send(9, 0, 0, 0, 0, 0, 32'd0);
    send(0, 1, 2, 3, 0, 0, 32'd0);

    out_ready = 1'b0;
    send(0, 4, 5, 6, 5, 1, 32'd0);
    send(2, 4, 5, 0, 2, 0, 32'hFFFF_FFFC);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(4, 0, 1, 2, 1, 0, 32'hFFFF_F000);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
